// File: rtl/mul_pkg.sv
// Shared types and defaults for the shift-add multiplier front-end sequencer.
// Imported by the sequencer top and its watchdog counter.
package mul_pkg;

  localparam int MUL_W              = 32;
  localparam int DEFAULT_MAX_CYCLES = 65535;
  localparam int DEFAULT_TW         = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/mul_seq_watchdog.sv
// Saturating cycle counter that flags when a multiplier run has taken MAX_CYCLES cycles.
// Held at zero while clr is high; counts only while en is high.
module mul_seq_watchdog
  import mul_pkg::*;
#(
  parameter int TW         = DEFAULT_TW,
  parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TW-1:0] LIMIT = TW'(MAX_CYCLES - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Saturate at all-ones so a missed exit can never wrap back below LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/mul_operand_seq.sv
// Operand sequencer in front of the shift-add multiplier: accepts {A,B}, feeds them over
// the shared data bus, waits for done (with watchdog) and returns the product.
module mul_operand_seq
  import mul_pkg::*;
#(
  parameter int W          = MUL_W,
  parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES,
  parameter int TW         = DEFAULT_TW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_prod,
  output logic         out_err,
  output logic         mul_start,
  output logic [W-1:0] mul_data,
  input  logic         mul_done,
  input  logic [W-1:0] mul_y
);

  seq_state_t   state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         mul_start_q, mul_start_d;
  logic [W-1:0] mul_data_q, mul_data_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_prod_q, out_prod_d;
  logic         out_err_q, out_err_d;

  logic wd_clr;
  logic wd_en;
  logic wd_expired;

  assign wd_clr = (state_q != WAIT);
  assign wd_en  = (state_q == WAIT);

  mul_seq_watchdog #(
    .TW         (TW),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // A sticky done left over from a previous run must block new work until reset.
  assign in_ready = rst_n && (state_q == IDLE) && !mul_done;

  // Bus outputs are computed for the state being entered so they are registered.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mul_start_d = 1'b0;
    mul_data_d  = '0;
    out_valid_d = out_valid_q;
    out_prod_d  = out_prod_q;
    out_err_d   = out_err_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d         = in_a;
          b_d         = in_b;
          mul_start_d = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        mul_data_d = a_q;
        state_d    = LOAD_A;
      end
      LOAD_A: begin
        mul_data_d = b_q;
        state_d    = LOAD_B;
      end
      LOAD_B: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          out_prod_d  = mul_y;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = RESP;
        end else if (wd_expired) begin
          out_prod_d  = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mul_start_q <= 1'b0;
      mul_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mul_start_q <= mul_start_d;
      mul_data_q  <= mul_data_d;
      out_valid_q <= out_valid_d;
      out_prod_q  <= out_prod_d;
      out_err_q   <= out_err_d;
    end
  end

  assign mul_start = mul_start_q;
  assign mul_data  = mul_data_q;
  assign out_valid = out_valid_q;
  assign out_prod  = out_prod_q;
  assign out_err   = out_err_q;

endmodule
